// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial audio link plus parallel word outputs of the I2S receiver.
// master = side that drives lrclk/sdata and consumes the decoded words,
// slave  = the receiver itself.
interface i2s_rx_if #(
  parameter int AUDIO_DW = 32
);
  logic                lrclk;
  logic                sdata;
  logic [AUDIO_DW-1:0] left_chan;
  logic [AUDIO_DW-1:0] right_chan;
  logic                valid;
  logic                locked;
  logic                frame_err;

  modport master (
    output lrclk, sdata,
    input  left_chan, right_chan, valid, locked, frame_err
  );

  modport slave (
    input  lrclk, sdata,
    output left_chan, right_chan, valid, locked, frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: left-justified I2S receiver. The MSB arrives on the same sclk as the
// lrclk transition; lrclk=0 carries the left word, lrclk=1 the right word.
// A left/right pair is presented with a one-cycle valid once both words of a
// frame have arrived with exactly AUDIO_DW bits each; any short or long word
// raises a one-cycle frame_err and drops lock until the next falling lrclk.
// Optional macro I2S_RX_ERRCNT_EN adds err_cnt, a saturating 8-bit count of
// frame_err pulses.
module i2s_rx #(
  parameter int AUDIO_DW = 32
) (
  input  logic       sclk,
  input  logic       rst,
  i2s_rx_if.slave    bus
`ifdef I2S_RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int              CW       = $clog2(AUDIO_DW + 1);
  localparam int              SHW      = AUDIO_DW - 1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(AUDIO_DW);
  localparam logic [CW-1:0]   CNT_LAST = CW'(AUDIO_DW - 1);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  lr_q;
  logic                  lr_edge;
  logic [CW-1:0]         cnt;
  // Only the first AUDIO_DW-1 bits are ever stored; the last bit is joined
  // with them directly on the completing edge, so the word's MSB is never lost.
  logic [SHW-1:0]        shreg;
  logic [AUDIO_DW-1:0]   word_done;
  logic [AUDIO_DW-1:0]   left_hold;
  logic                  left_ok;
  logic                  start_word;
  logic                  shift_en;
  logic                  err;
  logic                  complete;

  assign lr_edge    = bus.lrclk ^ lr_q;
  assign word_done  = {shreg, bus.sdata};
  assign complete   = shift_en && (cnt == CNT_LAST);
  assign bus.locked = (state != UNSYNC);

  // Framing state register.
  always_ff @(posedge sclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, whatever the block order.
    if (rst) state <= UNSYNC;
    else     state <= state_nxt;
  end

  // Next-state decode: classify each sampled bit as new word, shift or error.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nxt  = state;
    start_word = 1'b0;
    shift_en   = 1'b0;
    err        = 1'b0;
    unique case (state)
      UNSYNC: begin
        // Only a falling edge marks a left-word MSB we can trust.
        if (lr_edge && !bus.lrclk) begin
          state_nxt  = LEFT;
          start_word = 1'b1;
        end
      end
      LEFT, RIGHT: begin
        if (lr_edge) begin
          if (cnt == CNT_FULL) begin
            state_nxt  = bus.lrclk ? RIGHT : LEFT;
            start_word = 1'b1;
          end else begin
            // Short word: this edge is not reused for resync.
            state_nxt = UNSYNC;
            err       = 1'b1;
          end
        end else if (cnt == CNT_FULL) begin
          // Long word: one bit more than a channel can carry.
          state_nxt = UNSYNC;
          err       = 1'b1;
        end else begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = UNSYNC;
    endcase
  end

  // Shift register, bit counter, pairing of left/right words and pulses.
  always_ff @(posedge sclk) begin
    if (rst) begin
      // NOTE: shreg and left_hold are left out of reset; they are only ever
      // read after a fresh word has overwritten them, so reset buys nothing.
      lr_q           <= 1'b1;
      cnt            <= '0;
      left_ok        <= 1'b0;
      bus.left_chan  <= '0;
      bus.right_chan <= '0;
      bus.valid      <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      lr_q          <= bus.lrclk;
      bus.valid     <= 1'b0;
      bus.frame_err <= err;

      if (start_word) begin
        shreg <= SHW'(bus.sdata);
        cnt   <= CW'(1);
      end

      if (shift_en) begin
        shreg <= SHW'({shreg, bus.sdata});
        cnt   <= cnt + 1'b1;
      end

      if (err) left_ok <= 1'b0;

      if (complete) begin
        if (state == LEFT) begin
          left_hold <= word_done;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          bus.left_chan  <= left_hold;
          bus.right_chan <= word_done;
          bus.valid      <= 1'b1;
          left_ok        <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_ERRCNT_EN
  // Saturating count of framing errors since reset.
  always_ff @(posedge sclk) begin
    if (rst)                          err_cnt <= 8'd0;
    else if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx. Stimulus is described as lrclk "runs"
// (constant-lrclk stretches with their data word); a run-level model derives
// the expected outputs after every sampled bit and one compare process checks
// the DUT each cycle. Literal checks pin the model's results.
module tb_i2s_rx;

  localparam int DW = 32;

  typedef struct packed {
    logic          valid;
    logic          err;
    logic          locked;
    logic [DW-1:0] left;
    logic [DW-1:0] right;
  } exp_t;

  logic sclk;
  logic rst;
  logic [7:0] err_cnt;

  i2s_rx_if #(.AUDIO_DW(DW)) bus ();

  i2s_rx #(.AUDIO_DW(DW)) dut (
    .sclk    (sclk),
    .rst     (rst),
    .bus     (bus)
`ifdef I2S_RX_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

`ifndef I2S_RX_ERRCNT_EN
  assign err_cnt = 8'd0;
`endif

  initial sclk = 1'b1;
  always #5 sclk = ~sclk;

  int   tests;
  int   fails;
  int   cyc;
  int   n_valid;
  int   n_err;
  int   first_valid_cyc;
  int   last_valid_cyc;
  int   last_gap;
  exp_t exp_q[$];

  // Run-level model state.
  logic          m_prev_lr;
  logic          m_lock;
  logic          m_left_ok;
  int            m_prev_len;
  logic [DW-1:0] m_left_word;
  logic [DW-1:0] m_held_l;
  logic [DW-1:0] m_held_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic d, input exp_t e);
    @(negedge sclk);
    rst       = r;
    bus.lrclk = l;
    bus.sdata = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n, input logic lr);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) drive(1'b1, lr, 1'b0, e);
    m_prev_lr  = 1'b1;
    m_lock     = 1'b0;
    m_left_ok  = 1'b0;
    m_prev_len = 0;
    m_held_l   = '0;
    m_held_r   = '0;
  endtask

  // One constant-lrclk stretch of len bits; word supplies the first DW bits.
  task automatic play_run(input logic lr, input int len, input logic [DW-1:0] word);
    logic is_edge;
    logic used;
    logic err0;
    exp_t e;
    logic b;
    is_edge = (lr != m_prev_lr);
    used    = 1'b0;
    err0    = 1'b0;
    if (is_edge) begin
      if (m_lock) begin
        if (m_prev_len == DW) used = 1'b1;
        else begin
          err0      = 1'b1;
          m_lock    = 1'b0;
          m_left_ok = 1'b0;
        end
      end else if (lr == 1'b0) begin
        used   = 1'b1;
        m_lock = 1'b1;
      end
    end
    for (int i = 0; i < len; i++) begin
      e = '0;
      b = (i < DW) ? word[DW-1-i] : i[0];
      if (i == 0 && err0) e.err = 1'b1;
      if (used && m_lock) begin
        if (i == DW - 1) begin
          if (lr == 1'b0) begin
            m_left_word = word;
            m_left_ok   = 1'b1;
          end else if (m_left_ok) begin
            m_held_l  = m_left_word;
            m_held_r  = word;
            e.valid   = 1'b1;
            m_left_ok = 1'b0;
          end
        end
        if (i == DW) begin
          e.err     = 1'b1;
          m_lock    = 1'b0;
          m_left_ok = 1'b0;
        end
      end
      e.locked = m_lock;
      e.left   = m_held_l;
      e.right  = m_held_r;
      drive(1'b0, lr, b, e);
    end
    m_prev_len = used ? len : 0;
    m_prev_lr  = lr;
  endtask

  task automatic play_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    play_run(1'b0, DW, l);
    play_run(1'b1, DW, r);
  endtask

  // Wait until the most recently driven bit has been sampled and compared.
  task automatic settle();
    @(posedge sclk);
    #2;
  endtask

  // Per-cycle compare against the model's expectation for the bit just sampled.
  always @(posedge sclk) begin
    exp_t e;
    cyc++;
    #1;
    if (bus.valid === 1'b1) begin
      n_valid++;
      if (first_valid_cyc == 0) first_valid_cyc = cyc;
      if (last_valid_cyc != 0) last_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) n_err++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid",      64'(bus.valid),      64'(e.valid));
      check("frame_err",  64'(bus.frame_err),  64'(e.err));
      check("locked",     64'(bus.locked),     64'(e.locked));
      check("left_chan",  64'(bus.left_chan),  64'(e.left));
      check("right_chan", 64'(bus.right_chan), 64'(e.right));
      check("valid_excl_err", 64'(bus.valid & bus.frame_err), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int e0;
    logic [DW-1:0] l;
    tests = 0; fails = 0; cyc = 0; n_valid = 0; n_err = 0;
    first_valid_cyc = 0; last_valid_cyc = 0; last_gap = 0;
    rst = 1'b1; bus.lrclk = 1'b0; bus.sdata = 1'b0;

    // Reset state.
    do_reset(4, 1'b0);
    settle();
    check("rst_valid",  64'(bus.valid), 64'd0);
    check("rst_locked", 64'(bus.locked), 64'd0);
    check("rst_left",   64'(bus.left_chan), 64'd0);

    // Fixed-data loopback: lock on first falling edge, valid every 64 sclk.
    play_run(1'b0, DW, 32'hA5A5_0001);
    settle();
    check("locked_after_fall", 64'(bus.locked), 64'd1);
    play_run(1'b1, DW, 32'h8000_FFFF);
    play_frame(32'hA5A5_0001, 32'h8000_FFFF);
    play_frame(32'hA5A5_0001, 32'h8000_FFFF);
    settle();
    check("first_valid_cyc", 64'(first_valid_cyc), 64'd68);
    check("valid_gap",       64'(last_gap),        64'd64);
    check("lb_nvalid",       64'(n_valid),         64'd3);
    check("lb_left",         64'(bus.left_chan),   64'hA5A5_0001);
    check("lb_right",        64'(bus.right_chan),  64'h8000_FFFF);
    check("lb_nerr",         64'(n_err),           64'd0);

    // Changing data every frame: no skipped or duplicated pairs.
    v0 = n_valid;
    for (int k = 0; k < 4; k++) begin
      l = 32'h0000_0100 + 32'(k);
      play_frame(l, ~l);
    end
    settle();
    check("inc_nvalid", 64'(n_valid - v0),    64'd4);
    check("inc_left",   64'(bus.left_chan),   64'h0000_0103);
    check("inc_right",  64'(bus.right_chan),  64'hFFFF_FEFC);

    // Short right word (20 bits), resync on the falling edge after the next.
    v0 = n_valid; e0 = n_err;
    play_run(1'b0, DW, 32'h1234_5678);
    play_run(1'b1, 20, 32'hDEAD_BEEF);
    play_run(1'b0, DW, 32'h0BAD_0BAD);
    settle();
    check("short_locked", 64'(bus.locked), 64'd0);
    play_run(1'b1, DW, 32'h0BAD_0BAD);
    play_frame(32'hCAFE_0001, 32'hCAFE_0002);
    settle();
    check("short_nerr",   64'(n_err - e0),   64'd1);
    check("short_nvalid", 64'(n_valid - v0), 64'd1);
    check("short_left",   64'(bus.left_chan), 64'hCAFE_0001);

    // Long left word (33 bits).
    v0 = n_valid; e0 = n_err;
    play_run(1'b0, DW + 1, 32'h5555_AAAA);
    settle();
    check("long_locked", 64'(bus.locked), 64'd0);
    play_run(1'b1, DW, 32'h7777_7777);
    play_frame(32'h1357_9BDF, 32'h2468_ACE0);
    settle();
    check("long_nerr",   64'(n_err - e0),    64'd1);
    check("long_nvalid", 64'(n_valid - v0),  64'd1);
    check("long_right",  64'(bus.right_chan), 64'h2468_ACE0);

    // Release reset in the right channel mid-word.
    v0 = n_valid;
    do_reset(2, 1'b1);
    play_run(1'b1, 10, 32'hFFFF_0000);
    settle();
    check("rstart_locked", 64'(bus.locked), 64'd0);
    play_frame(32'h0F0F_0F0F, 32'hF0F0_F0F0);
    settle();
    check("rstart_nvalid", 64'(n_valid - v0), 64'd1);

    // Reset during a left word of a locked stream.
    play_frame(32'h1111_2222, 32'h3333_4444);
    play_run(1'b0, 15, 32'h9999_9999);
    do_reset(3, 1'b0);
    settle();
    check("midrst_valid",  64'(bus.valid),      64'd0);
    check("midrst_locked", 64'(bus.locked),     64'd0);
    check("midrst_right",  64'(bus.right_chan), 64'd0);
    play_frame(32'hABCD_EF01, 32'h2345_6789);
    settle();
    check("midrst_left", 64'(bus.left_chan), 64'hABCD_EF01);

`ifdef I2S_RX_ERRCNT_EN
    // 300 framing errors from alternating one-bit runs; counter saturates.
    e0 = n_err;
    for (int k = 0; k < 300; k++) begin
      play_run(1'b0, 1, '0);
      play_run(1'b1, 1, '1);
    end
    settle();
    check("errcnt_nerr", 64'(n_err - e0), 64'd300);
    check("errcnt_sat",  64'(err_cnt),    64'd255);
    do_reset(2, 1'b0);
    settle();
    check("errcnt_rst",  64'(err_cnt),    64'd0);
`endif

    check("model_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver: deserialises a left-justified serial audio stream into parallel left and right words.
- Direct downstream counterpart of the team's i2s_tx; lrclk and sdata from i2s_tx connect straight to this block.
- MSB coincides with the lrclk transition (no one-bit delay). lrclk=0 is the left channel, lrclk=1 is the right channel.
- Each channel carries exactly AUDIO_DW bits.

Parameters:
AUDIO_DW, 32, bits per channel word; ≥2.

Ports:
sclk  in  1  bit clock; all logic on posedge sclk
rst  in  1  reset, synchronous, active-high
lrclk  in  1  word select (0=left, 1=right); sampled on posedge sclk
sdata  in  1  serial data, MSB first; sampled on posedge sclk
left_chan  out  AUDIO_DW  last complete left word
right_chan  out  AUDIO_DW  last complete right word
valid  out  1  one-cycle pulse: new left/right pair on outputs
locked  out  1  1 when framed (state LEFT or RIGHT)
frame_err  out  1  one-cycle pulse on framing violation

Behaviour:
- Internal registers:
  - lr_q: previous lrclk; resets to 1.
  - state: UNSYNC, LEFT or RIGHT.
  - cnt: bits received in the current word, 0..AUDIO_DW, width $clog2(AUDIO_DW+1).
  - shreg: AUDIO_DW-bit shift register.
  - left_hold, left_ok.
- Every edge, lr_q <= lrclk. edge = lrclk ^ lr_q.
- Reset values: state=UNSYNC, cnt=0, left_ok=0, left_chan=0, right_chan=0, valid=0, frame_err=0; locked=0 (locked is a decode of state).
- Reset mid-word discards all partial data. No valid is produced until a full new L+R pair is received.
- Shifting is MSB first: shreg <= {shreg[AUDIO_DW-2:0], sdata}. A "new word" sets shreg <= {0.., sdata} and cnt <= 1.
- UNSYNC:
  - Wait for a falling edge (edge && lrclk==0). Then state <= LEFT and start a new word.
  - Rising edges and steady lrclk are ignored.
- LEFT/RIGHT, edge and cnt==AUDIO_DW (good boundary):
  - state <= lrclk ? RIGHT : LEFT.
  - Start a new word.
- LEFT/RIGHT, edge and cnt<AUDIO_DW (short word):
  - frame_err <= 1 for one cycle.
  - state <= UNSYNC, left_ok <= 0.
  - The bit is discarded. Resync happens at the next falling edge, never at the current edge.
- LEFT/RIGHT, no edge and cnt==AUDIO_DW (long word):
  - frame_err pulse, state <= UNSYNC, left_ok <= 0.
- LEFT/RIGHT, no edge and cnt<AUDIO_DW:
  - Shift in sdata; cnt <= cnt+1.
- Word completion (the shift that makes cnt==AUDIO_DW):
  - In LEFT: left_hold <= completed word, left_ok <= 1.
  - In RIGHT with left_ok=1: left_chan <= left_hold, right_chan <= completed word, valid <= 1, left_ok <= 0.
  - In RIGHT with left_ok=0: the word is dropped and valid is not asserted.
- Latency: valid and the outputs update on the same posedge that samples the right-channel LSB. They are visible for the following cycle. Outputs hold until the next valid.
- valid and frame_err are never asserted together.
- With i2s_tx in loopback, steady state gives one valid every 2*AUDIO_DW sclk and frame_err stays 0.

Optional Feature:
- Macro I2S_RX_ERRCNT_EN.
- When defined: adds output err_cnt [7:0].
  - Reset to 0.
  - Increments on each frame_err pulse.
  - Saturates at 255; no wrap.
- When undefined: no err_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Loopback with i2s_tx (AUDIO_DW=32), left=32'hA5A5_0001, right=32'h8000_FFFF, rst held 4 cycles:
  - locked=1 after the first falling lrclk edge.
  - First valid after the first complete L+R frame, then every 64 sclk.
  - left_chan/right_chan equal the driven values; frame_err never 1.
- Loopback, change inputs every frame (incrementing left, ~left for right) -> each valid presents the matching pair, no skipped or duplicated frames.
- Short word: bench toggles lrclk after 20 right-channel bits ->
  - frame_err pulses 1 cycle; locked drops to 0; no valid for that frame.
  - After the next falling edge plus a full correct L+R, valid returns with correct data.
- Long word: hold lrclk=0 for 33 bits -> frame_err pulses when the 33rd bit is sampled; locked=0; resyncs on the next falling edge.
- Start in right channel: release rst with lrclk=1 mid-word ->
  - Ignored until the falling edge.
  - A right word received with left_ok=0 produces no valid.
  - First valid comes after a complete left+right.
- Reset mid-operation: assert rst during the left word of a locked stream -> next cycle valid=0, locked=0, outputs=0; clean resync afterwards. With I2S_RX_ERRCNT_EN: 300 injected errors -> err_cnt=255, and rst clears it to 0.
